// File: rtl/sensor_scheduler_rr_pkg.sv
// Shared types and constants for the round-robin sensor scheduler.
package sensor_sched_pkg;

    typedef enum logic {
        IDLE      = 1'b0,
        WAIT_DONE = 1'b1
    } sched_state_e;

    localparam logic [7:0] ERR_CNT_MAX = 8'd255;

    function automatic int ch_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sensor_scheduler_rr_if.sv
// Start/done handshake between the scheduler and the UART transmitter.
interface sensor_scheduler_rr_if
    import sensor_sched_pkg::*;
#(
    parameter int N_CH   = 8,
    parameter int DATA_W = 16
);
    localparam int CH_W = ch_width(N_CH);

    logic [DATA_W-1:0] tx_data;
    logic [CH_W-1:0]   tx_ch;
    logic              tx_en;
    logic              tx_done;

    modport master (output tx_data, output tx_ch, output tx_en, input tx_done);
    modport slave  (input tx_data, input tx_ch, input tx_en, output tx_done);

endinterface

// File: rtl/sensor_scheduler_rr_arbiter.sv
// Round-robin grant: lowest set request at or above ptr, wrapping to channel 0.
module sched_rr_arbiter
    import sensor_sched_pkg::*;
#(
    parameter  int N_CH = 8,
    localparam int CH_W = ch_width(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [CH_W-1:0] ptr,
    output logic            any,
    output logic [CH_W-1:0] grant
);

    logic [2*N_CH-1:0] masked;

    // Upper copy of req is never masked, so it supplies the wrapped-around candidates.
    always_comb begin
        masked = '0;
        for (int i = 0; i < 2*N_CH; i++) begin
            masked[i] = req[i % N_CH] && (i >= int'(ptr));
        end
    end

    always_comb begin
        grant = '0;
        for (int i = 2*N_CH-1; i >= 0; i--) begin
            if (masked[i]) grant = CH_W'(i % N_CH);
        end
    end

    assign any = |req;

endmodule

// File: rtl/sensor_scheduler_rr.sv
// Polls N_CH sensor channels round-robin and forwards one word at a time to the
// UART transmitter, abandoning transfers the transmitter never finishes.
module sensor_scheduler_rr
    import sensor_sched_pkg::*;
#(
    parameter int N_CH        = 8,
    parameter int DATA_W      = 16,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_CH-1:0]          sensor_ready,
    input  logic [N_CH*DATA_W-1:0]   sensor_bus,
    input  logic [N_CH-1:0]          ch_enable,
    sensor_scheduler_rr_if.master    tx_if,
    output logic [N_CH-1:0]          data_used,
    output logic                     busy,
    output logic                     timeout_err,
    output logic [7:0]               err_count
);

    localparam int              CH_W     = ch_width(N_CH);
    localparam int              TMR_W    = $clog2(TIMEOUT_CYC);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(N_CH - 1);

    sched_state_e      state_q, state_d;
    logic [CH_W-1:0]   ptr_q, ptr_d;
    logic [CH_W-1:0]   tx_ch_q, tx_ch_d;
    logic [CH_W-1:0]   grant;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic [N_CH-1:0]   data_used_q, data_used_d;
    logic [N_CH-1:0]   req;
    logic              tx_en_q, tx_en_d;
    logic              busy_q, busy_d;
    logic              terr_q, terr_d;
    logic [7:0]        err_q, err_d;
    logic              any_req, done_ok, tmo_hit;

    assign req = sensor_ready & ch_enable;

    sched_rr_arbiter #(.N_CH(N_CH)) u_arb (
        .req   (req),
        .ptr   (ptr_q),
        .any   (any_req),
        .grant (grant)
    );

    // tx_en_q marks the first WAIT_DONE cycle, where tx_done cannot belong to this frame.
    assign done_ok = tx_if.tx_done && !tx_en_q;
    assign tmo_hit = (timer_q == TMR_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            timer_q     <= '0;
            tx_data_q   <= '0;
            tx_ch_q     <= '0;
            tx_en_q     <= 1'b0;
            data_used_q <= '0;
            busy_q      <= 1'b0;
            terr_q      <= 1'b0;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            timer_q     <= timer_d;
            tx_data_q   <= tx_data_d;
            tx_ch_q     <= tx_ch_d;
            tx_en_q     <= tx_en_d;
            data_used_q <= data_used_d;
            busy_q      <= busy_d;
            terr_q      <= terr_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (any_req) state_d = WAIT_DONE;
            WAIT_DONE: if (done_ok || tmo_hit) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        ptr_d       = ptr_q;
        timer_d     = timer_q;
        tx_data_d   = tx_data_q;
        tx_ch_d     = tx_ch_q;
        tx_en_d     = 1'b0;
        data_used_d = '0;
        busy_d      = busy_q;
        terr_d      = 1'b0;
        err_d       = err_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    tx_data_d          = sensor_bus[int'(grant)*DATA_W +: DATA_W];
                    tx_ch_d            = grant;
                    tx_en_d            = 1'b1;
                    data_used_d[grant] = 1'b1;
                    busy_d             = 1'b1;
                    ptr_d              = (grant == CH_LAST) ? '0 : grant + CH_W'(1);
                    timer_d            = '0;
                end
            end
            WAIT_DONE: begin
                if (done_ok) begin
                    busy_d = 1'b0;
                end else if (tmo_hit) begin
                    terr_d = 1'b1;
                    busy_d = 1'b0;
                    if (err_q != ERR_CNT_MAX) err_d = err_q + 8'd1;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            default: ;
        endcase
    end

    assign tx_if.tx_data = tx_data_q;
    assign tx_if.tx_ch   = tx_ch_q;
    assign tx_if.tx_en   = tx_en_q;
    assign data_used     = data_used_q;
    assign busy          = busy_q;
    assign timeout_err   = terr_q;
    assign err_count     = err_q;

endmodule

// File: tb/tb_sensor_scheduler_rr.sv
// Directed bench for sensor_scheduler_rr (8 channels, 16-bit words, 20-cycle timeout).
module tb_sensor_scheduler_rr;

    logic         clk;
    logic         rst;
    logic [7:0]   sensor_ready;
    logic [127:0] sensor_bus;
    logic [7:0]   ch_enable;
    logic [7:0]   data_used;
    logic         busy;
    logic         timeout_err;
    logic [7:0]   err_count;
    logic [7:0]   du_acc;
    int           checks;
    int           errors;

    sensor_scheduler_rr_if #(.N_CH(8), .DATA_W(16)) tif ();

    sensor_scheduler_rr #(.N_CH(8), .DATA_W(16), .TIMEOUT_CYC(20)) dut (
        .clk          (clk),
        .rst          (rst),
        .sensor_ready (sensor_ready),
        .sensor_bus   (sensor_bus),
        .ch_enable    (ch_enable),
        .tx_if        (tif),
        .data_used    (data_used),
        .busy         (busy),
        .timeout_err  (timeout_err),
        .err_count    (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] word_of(input int i);
        return (i == 2) ? 16'hBEEF : 16'(16'hA000 + i * 16'h0111);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        du_acc = du_acc | data_used;
    endtask

    task automatic wait_tx_en(input string tag, input int budget);
        int n = 0;
        do begin
            step();
            n++;
        end while (!tif.tx_en && n < budget);
        chk(tag, 32'(tif.tx_en), 32'd1);
    endtask

    task automatic wait_timeout(input string tag, input int budget);
        int n = 0;
        do begin
            step();
            n++;
        end while (!timeout_err && n < budget);
        chk(tag, 32'(timeout_err), 32'd1);
    endtask

    task automatic finish_done(input int n);
        repeat (n) step();
        tif.tx_done = 1'b1;
        step();
        tif.tx_done = 1'b0;
        chk("busy_after_done", 32'(busy), 32'd0);
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        du_acc       = '0;
        rst          = 1'b1;
        sensor_ready = '0;
        ch_enable    = 8'hFF;
        tif.tx_done  = 1'b0;
        for (int i = 0; i < 8; i++) sensor_bus[i*16 +: 16] = word_of(i);

        // Reset state
        step();
        step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_tx_en", 32'(tif.tx_en), 32'd0);
        chk("rst_data_used", 32'(data_used), 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        chk("rst_timeout_err", 32'(timeout_err), 32'd0);
        chk("rst_tx_data", 32'(tif.tx_data), 32'd0);
        rst = 1'b0;

        // Enable mask 0x81 from ptr=0: grants 0,7,0,7
        du_acc       = '0;
        ch_enable    = 8'h81;
        sensor_ready = 8'hFF;
        for (int k = 0; k < 4; k++) begin
            wait_tx_en("mask_tx_en", 10);
            chk("mask_tx_ch", 32'(tif.tx_ch), (k % 2 == 1) ? 32'd7 : 32'd0);
            chk("mask_data_used", 32'(data_used), (k % 2 == 1) ? 32'h80 : 32'h01);
            finish_done(5);
        end
        sensor_ready = '0;
        chk("mask_used_bits", 32'(du_acc), 32'h81);
        ch_enable = 8'hFF;

        // Round-robin, all ready: grants 0..7,0
        sensor_ready = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            wait_tx_en("rr_tx_en", 10);
            chk("rr_tx_ch", 32'(tif.tx_ch), 32'(k % 8));
            chk("rr_data_used", 32'(data_used), 32'(8'h01 << (k % 8)));
            chk("rr_tx_data", 32'(tif.tx_data), 32'(word_of(k % 8)));
            finish_done(5);
        end
        sensor_ready = '0;

        // Single request on ch2, ptr=1
        sensor_ready = 8'h04;
        wait_tx_en("single_tx_en", 10);
        chk("single_data_used", 32'(data_used), 32'h04);
        chk("single_tx_ch", 32'(tif.tx_ch), 32'd2);
        chk("single_tx_data", 32'(tif.tx_data), 32'hBEEF);
        chk("single_busy", 32'(busy), 32'd1);
        sensor_ready = '0;
        step();
        chk("single_tx_en_drop", 32'(tif.tx_en), 32'd0);
        chk("single_du_drop", 32'(data_used), 32'd0);
        sensor_bus[2*16 +: 16] = 16'h1234;
        ch_enable = 8'h00;
        finish_done(9);
        chk("single_tx_data_hold", 32'(tif.tx_data), 32'hBEEF);
        sensor_bus[2*16 +: 16] = word_of(2);
        ch_enable = 8'hFF;

        // Timeout on ch4, then next grant ch5
        sensor_ready = 8'h10;
        wait_tx_en("tmo_tx_en", 10);
        chk("tmo_tx_ch", 32'(tif.tx_ch), 32'd4);
        sensor_ready = '0;
        repeat (19) step();
        chk("tmo_not_yet", 32'(timeout_err), 32'd0);
        chk("tmo_busy_pre", 32'(busy), 32'd1);
        sensor_ready = 8'h20;
        step();
        chk("tmo_pulse", 32'(timeout_err), 32'd1);
        chk("tmo_err_count", 32'(err_count), 32'd1);
        chk("tmo_busy", 32'(busy), 32'd0);
        step();
        chk("tmo_next_tx_en", 32'(tif.tx_en), 32'd1);
        chk("tmo_next_tx_ch", 32'(tif.tx_ch), 32'd5);
        chk("tmo_pulse_end", 32'(timeout_err), 32'd0);
        sensor_ready = '0;
        finish_done(2);

        // Races on ch6: done in tx_en cycle ignored; done on last timer cycle wins
        sensor_ready = 8'h40;
        wait_tx_en("race_tx_en", 10);
        chk("race_tx_ch", 32'(tif.tx_ch), 32'd6);
        tif.tx_done  = 1'b1;
        sensor_ready = '0;
        step();
        tif.tx_done = 1'b0;
        chk("race_early_done_busy", 32'(busy), 32'd1);
        repeat (18) step();
        tif.tx_done = 1'b1;
        step();
        tif.tx_done = 1'b0;
        chk("race_no_tmo", 32'(timeout_err), 32'd0);
        chk("race_busy", 32'(busy), 32'd0);
        chk("race_err_count", 32'(err_count), 32'd1);
        step();
        chk("race_no_tmo_late", 32'(timeout_err), 32'd0);

        // Reset mid-transfer on ch5; afterwards ch0 wins over ch6
        sensor_ready = 8'h20;
        wait_tx_en("mid_tx_en", 10);
        chk("mid_tx_ch", 32'(tif.tx_ch), 32'd5);
        sensor_ready = '0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_tx_en", 32'(tif.tx_en), 32'd0);
        chk("mid_data_used", 32'(data_used), 32'd0);
        chk("mid_err_count", 32'(err_count), 32'd0);
        sensor_ready = 8'h41;
        wait_tx_en("mid_regrant_tx_en", 10);
        chk("mid_regrant_ch", 32'(tif.tx_ch), 32'd0);
        sensor_ready = '0;
        finish_done(3);

        // Saturation: 300 consecutive timeouts
        sensor_ready = 8'hFF;
        for (int i = 0; i < 300; i++) begin
            wait_tx_en("sat_tx_en", 5);
            wait_timeout("sat_timeout", 25);
            if (i == 254) chk("sat_err_255", 32'(err_count), 32'd255);
        end
        sensor_ready = '0;
        chk("sat_err_final", 32'(err_count), 32'd255);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
